// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU op sequencer: ARM opcodes, FSM encoding,
// logic-function codes, condition codes and the decoded control bundle.
package alu_op_sequencer_pkg;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2;

  localparam logic [1:0] LF_AND = 2'b00, LF_ORR = 2'b01, LF_EOR = 2'b10, LF_PASS = 2'b11;

  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;

  typedef struct packed {
    logic       invert_a;
    logic       invert_b;
    logic       is_logic;
    logic [1:0] logic_func;
    logic       cin;
    logic       is_arith;
    logic       is_compare;
  } alu_ctrl_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond)
      CC_EQ:   r = z;
      CC_NE:   r = !z;
      CC_CS:   r = c;
      CC_CC:   r = !c;
      CC_MI:   r = n;
      CC_PL:   r = !n;
      CC_VS:   r = v;
      CC_VC:   r = !v;
      CC_HI:   r = c && !z;
      CC_LS:   r = !c || z;
      CC_GE:   r = (n == v);
      CC_LT:   r = (n != v);
      CC_GT:   r = !z && (n == v);
      CC_LE:   r = z || (n != v);
      CC_AL:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bus of the ALU op sequencer. req_cond exists only when
// ALU_COND_EN is defined.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic             req_s;
  logic [3:0]       req_rd;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_shift_c;
`ifdef ALU_COND_EN
  logic [3:0]       req_cond;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_rd;
  logic             rsp_wr_en;

  modport master (
    output req_valid, req_opcode, req_s, req_rd, req_a, req_b, req_shift_c,
`ifdef ALU_COND_EN
    output req_cond,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_rd, rsp_wr_en
  );

  modport slave (
    input  req_valid, req_opcode, req_s, req_rd, req_a, req_b, req_shift_c,
`ifdef ALU_COND_EN
    input  req_cond,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_rd, rsp_wr_en
  );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// ARM data-processing opcode -> ALU control decode. Purely combinational;
// c_flag_i is the committed carry used by ADC/SBC/RSC.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       c_flag_i,
  output alu_ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_AND, OP_TST: begin ctrl_o.is_logic = 1'b1; ctrl_o.logic_func = LF_AND; end
      OP_EOR, OP_TEQ: begin ctrl_o.is_logic = 1'b1; ctrl_o.logic_func = LF_EOR; end
      OP_SUB, OP_CMP: begin ctrl_o.invert_b = 1'b1; ctrl_o.cin = 1'b1; end
      OP_RSB:         begin ctrl_o.invert_a = 1'b1; ctrl_o.cin = 1'b1; end
      OP_ADC:         ctrl_o.cin = c_flag_i;
      OP_SBC:         begin ctrl_o.invert_b = 1'b1; ctrl_o.cin = c_flag_i; end
      OP_RSC:         begin ctrl_o.invert_a = 1'b1; ctrl_o.cin = c_flag_i; end
      OP_ORR:         begin ctrl_o.is_logic = 1'b1; ctrl_o.logic_func = LF_ORR; end
      OP_MOV:         begin ctrl_o.is_logic = 1'b1; ctrl_o.logic_func = LF_PASS; end
      OP_BIC:         begin ctrl_o.invert_b = 1'b1; ctrl_o.is_logic = 1'b1; ctrl_o.logic_func = LF_AND; end
      OP_MVN:         begin ctrl_o.invert_b = 1'b1; ctrl_o.is_logic = 1'b1; ctrl_o.logic_func = LF_PASS; end
      default:        ;  // ADD, CMN: plain add, cin 0
    endcase
    ctrl_o.is_arith   = !ctrl_o.is_logic;
    ctrl_o.is_compare = (opcode_i[3:2] == 2'b10);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ARM data-processing op through an external ALU and owns the
// NZCV register. Define ALU_COND_EN to add condition-code gating via req_cond.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int ALU_LATENCY = 3,
  parameter int WIDTH       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [3:0]        flags_nzcv,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_invert_a,
  output logic              alu_invert_b,
  output logic              alu_is_logic,
  output logic              alu_cin,
  output logic              alu_isactive,
  output logic [1:0]        alu_logic_func,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v
);
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  alu_ctrl_t        dec, ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       rd_q, flags_q, pend_q;
  logic             shc_q, wr_q, commit_q;
  logic             cond_ok, accept, capture;

  alu_op_decode u_dec (.opcode_i(bus.req_opcode), .c_flag_i(flags_q[1]), .ctrl_o(dec));

`ifdef ALU_COND_EN
  assign cond_ok = cond_pass(bus.req_cond, flags_q);
`else
  assign cond_ok = 1'b1;
`endif
  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign capture = (state_q == ST_EXEC) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        // a failed condition skips the ALU entirely
        state_d = cond_ok ? ST_EXEC : ST_RESP;
        cnt_d   = 4'(ALU_LATENCY - 1);
      end
      ST_EXEC: if (cnt_q == 4'd0) state_d = ST_RESP;
               else               cnt_d   = cnt_q - 4'd1;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      flags_q  <= '0;
      pend_q   <= '0;
      shc_q    <= 1'b0;
      wr_q     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ctrl_q   <= dec;
        a_q      <= bus.req_a;
        b_q      <= bus.req_b;
        rd_q     <= bus.req_rd;
        shc_q    <= bus.req_shift_c;
        res_q    <= '0;
        wr_q     <= cond_ok && !dec.is_compare;
        commit_q <= cond_ok && (bus.req_s || dec.is_compare);
      end
      if (capture) begin
        // logic ops: C from the shifter, V preserved
        res_q  <= alu_result;
        pend_q <= {alu_n, alu_z,
                   ctrl_q.is_arith ? alu_c : shc_q,
                   ctrl_q.is_arith ? alu_v : flags_q[0]};
      end
      if ((state_q == ST_RESP) && bus.rsp_ready && commit_q) flags_q <= pend_q;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_result = res_q;
  assign bus.rsp_rd     = rd_q;
  assign bus.rsp_wr_en  = wr_q;

  assign flags_nzcv     = flags_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_invert_a   = ctrl_q.invert_a;
  assign alu_invert_b   = ctrl_q.invert_b;
  assign alu_is_logic   = ctrl_q.is_logic;
  assign alu_logic_func = ctrl_q.logic_func;
  assign alu_cin        = ctrl_q.cin;
  assign alu_isactive   = (state_q == ST_EXEC);
endmodule
